state_reg: RTL and testbench
============================

# state_reg

Game-board state memory for the snake SoC: a 32×32 grid of 4-bit cell states. The CPU writes and reads cells through a 32-bit bus port. The VGA renderer reads one cell per pixel through an independent display port. It sits between the CPU's memory-mapped I/O decode and the block-drawing logic.

## Interface
Parameters:
- none; the grid is fixed at 32×32 cells of 4 bits each.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-low; clears the whole grid.
- L_S  in  1  load/store select; 1 = store (write a cell from data_in), 0 = load (read only).
- reg_addr  in  10  CPU read address {y[9:5], x[4:0]}.
- xBlockNum  in  5  display-port cell column.
- yBlockNum  in  5  display-port cell row.
- data_in  in  32  store word: [13:9] = y, [8:4] = x, [3:0] = state, [31:14] = ignored.
- data_out  out  32  load word: {18'b0, reg_addr[9:5], reg_addr[4:0], cell[reg_addr]}.
- BlockState  out  4  state of cell (yBlockNum, xBlockNum).

## Operation
- Storage: 1024 cells of 4 bits each, indexed by {y, x}, y = row 0–31, x = column 0–31.
- Store: on a rising edge with rst = 1 and L_S = 1, cell {data_in[13:9], data_in[8:4]} ← data_in[3:0].
  - reg_addr is ignored for stores.
  - data_in[31:14] is ignored.
- Load: data_out is a combinational read of the cell at reg_addr.
  - Packed in the same layout as a store word.
  - Upper 18 bits are always 0.
  - Valid regardless of L_S.
- Display: BlockState is a read of the cell at {yBlockNum, xBlockNum}; independent of the CPU port.
- Every 5-bit coordinate is in range 0–31, so there is no out-of-range case and no wrap logic.
- Only one store per cycle; exactly one cell changes per store.

## Timing
- Reset: while rst = 0 at a rising edge, all 1024 cells become 0.
  - Reset overrides a simultaneous store (L_S = 1).
  - A store issued in the cycle rst returns to 1 takes effect normally.
  - After reset, data_out = {18'b0, reg_addr, 4'h0} and BlockState = 0.
- Store latency: the new value is visible on data_out and BlockState after the write edge.
  - With the macro off, visible in the same cycle right after the edge.
- Read-during-write to the same cell: before the edge, reads return the old value; no write-through bypass.
- data_out is always combinational from reg_addr plus cell contents.

## Configuration
- STATE_REG_DISP_PIPE_EN defined: BlockState is registered.
  - The value reflects {yBlockNum, xBlockNum} and cell contents sampled at the previous rising edge (1-cycle latency).
  - The register resets to 0 under rst = 0.
  - A store at edge N is visible on BlockState after edge N+1.
- STATE_REG_DISP_PIPE_EN undefined: BlockState is combinational, zero latency.
- data_out is unaffected by the macro.

## Test plan
- Reset: pre-write cells (2,1) = 9 and (31,31) = 0xF, hold rst = 0 for 2 edges -> BlockState = 0 and data_out[3:0] = 0 at both addresses.
- Store/read-back:
  - rst = 1, L_S = 1, data_in = 0x0000_0419, one edge.
  - Then L_S = 0, y = 2, x = 1, reg_addr = 10'b00010_00001.
  - Required: BlockState = 9, data_out = 0x0000_0419.
- Address ignored on store: data_in = 0x0000_3FF5 (y = 31, x = 31, state = 5) with reg_addr = 0 -> cell (31,31) = 5, cell (0,0) stays 0.
- Upper bits ignored: data_in = 0xFFFF_C023 (y = 0, x = 2, state = 3) -> cell (0,2) = 3; data_out at reg_addr = 10'h002 reads 0x0000_0023.
- Reset vs store: rst = 0 and L_S = 1 with data_in = 0x0419 on the same edge -> cell (2,1) = 0.
- Independent ports: reg_addr = (2,1) and display (31,31) simultaneously -> data_out[3:0] = 9 and BlockState = 5 in the same cycle (one cycle later with STATE_REG_DISP_PIPE_EN).

Source files
------------

// File: rtl/state_reg.sv
// rtl/state_reg.sv - 32x32 grid of 4-bit cell states with CPU and display read ports (option: STATE_REG_DISP_PIPE_EN)
module state_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        L_S,
  input  logic [9:0]  reg_addr,
  input  logic [4:0]  xBlockNum,
  input  logic [4:0]  yBlockNum,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  BlockState
);

  // Grid is kept flat: cell {y, x} lives at bits [{y, x}*4 +: 4].
  logic [4095:0] grid_q;
  logic [4095:0] grid_d;

  logic [9:0] wr_addr;
  logic [9:0] disp_addr;
  logic [3:0] cpu_cell;
  logic [3:0] disp_cell;

  // data_in[31:14] carries no meaning for a store.
  logic unused_hi;
  assign unused_hi = ^data_in[31:14];

  assign wr_addr   = data_in[13:4];
  assign disp_addr = {yBlockNum, xBlockNum};

  // Next grid contents: a store replaces exactly one cell, everything else holds.
  always_comb begin
    grid_d = grid_q;
    if (L_S) begin
      grid_d[{wr_addr, 2'b00} +: 4] = data_in[3:0];
    end
  end

  // Grid storage; reset wins over a store on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grid_q <= '0;
    end else begin
      grid_q <= grid_d;
    end
  end

  // Read ports see only stored contents, so a same-cycle store is not bypassed.
  always_comb begin
    cpu_cell  = grid_q[{reg_addr, 2'b00} +: 4];
    disp_cell = grid_q[{disp_addr, 2'b00} +: 4];
  end

  // CPU load word mirrors the store word layout with the upper bits zeroed.
  always_comb begin
    data_out = {18'b0, reg_addr, cpu_cell};
  end

`ifdef STATE_REG_DISP_PIPE_EN
  logic [3:0] blk_q;
  logic [3:0] blk_d;

  // Display cell sampled from pre-edge contents, giving one cycle of latency.
  always_comb begin
    blk_d = disp_cell;
  end

  // Display output register, cleared with the grid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_q <= 4'h0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign BlockState = blk_q;
`else
  assign BlockState = disp_cell;
`endif

endmodule

// File: tb/tb_state_reg.sv
// tb/tb_state_reg.sv - directed self-checking bench for state_reg
module tb_state_reg;

  logic        clk;
  logic        rst;
  logic        L_S;
  logic [9:0]  reg_addr;
  logic [4:0]  xBlockNum;
  logic [4:0]  yBlockNum;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  BlockState;

  int checks;
  int errors;

  state_reg dut (
    .clk        (clk),
    .rst        (rst),
    .L_S        (L_S),
    .reg_addr   (reg_addr),
    .xBlockNum  (xBlockNum),
    .yBlockNum  (yBlockNum),
    .data_in    (data_in),
    .data_out   (data_out),
    .BlockState (BlockState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs are then changed away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let a new display address reach BlockState.
  task automatic settle();
`ifdef STATE_REG_DISP_PIPE_EN
    step();
`endif
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    L_S = 1'b1;
    data_in = 32'h0000_0419;
    step();
    data_in = 32'h0000_3FFF;
    step();
    L_S = 1'b0;
    rst = 1'b0;
    step();
    step();
    reg_addr = 10'b00010_00001;
    yBlockNum = 5'd2;
    xBlockNum = 5'd1;
    settle();
    checks++;
    if (BlockState !== 4'h0) begin
      errors++;
      $display("FAIL reset_blk_2_1 got %h exp %h", BlockState, 4'h0);
    end
    checks++;
    if (data_out !== 32'h0000_0410) begin
      errors++;
      $display("FAIL reset_dout_2_1 got %h exp %h", data_out, 32'h0000_0410);
    end
    reg_addr = 10'h3FF;
    yBlockNum = 5'd31;
    xBlockNum = 5'd31;
    settle();
    checks++;
    if (BlockState !== 4'h0) begin
      errors++;
      $display("FAIL reset_blk_31_31 got %h exp %h", BlockState, 4'h0);
    end
    checks++;
    if (data_out !== 32'h0000_3FF0) begin
      errors++;
      $display("FAIL reset_dout_31_31 got %h exp %h", data_out, 32'h0000_3FF0);
    end
  endtask

  task automatic test_store_readback();
    rst = 1'b1;
    yBlockNum = 5'd2;
    xBlockNum = 5'd1;
    settle();
    L_S = 1'b1;
    data_in = 32'h0000_0419;
    step();
    L_S = 1'b0;
    reg_addr = 10'b00010_00001;
`ifdef STATE_REG_DISP_PIPE_EN
    #1;
    checks++;
    if (BlockState !== 4'h0) begin
      errors++;
      $display("FAIL pipe_latency got %h exp %h", BlockState, 4'h0);
    end
`endif
    settle();
    checks++;
    if (BlockState !== 4'h9) begin
      errors++;
      $display("FAIL readback_blk got %h exp %h", BlockState, 4'h9);
    end
    checks++;
    if (data_out !== 32'h0000_0419) begin
      errors++;
      $display("FAIL readback_dout got %h exp %h", data_out, 32'h0000_0419);
    end
  endtask

  task automatic test_addr_ignored();
    L_S = 1'b1;
    reg_addr = 10'h000;
    data_in = 32'h0000_3FF5;
    step();
    L_S = 1'b0;
    yBlockNum = 5'd31;
    xBlockNum = 5'd31;
    settle();
    checks++;
    if (data_out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL addr_ignored_cell00 got %h exp %h", data_out, 32'h0);
    end
    checks++;
    if (BlockState !== 4'h5) begin
      errors++;
      $display("FAIL addr_ignored_blk got %h exp %h", BlockState, 4'h5);
    end
  endtask

  task automatic test_upper_ignored();
    L_S = 1'b1;
    data_in = 32'hFFFF_C023;
    step();
    L_S = 1'b0;
    reg_addr = 10'h002;
    yBlockNum = 5'd0;
    xBlockNum = 5'd2;
    settle();
    checks++;
    if (data_out !== 32'h0000_0023) begin
      errors++;
      $display("FAIL upper_ignored_dout got %h exp %h", data_out, 32'h0000_0023);
    end
    checks++;
    if (BlockState !== 4'h3) begin
      errors++;
      $display("FAIL upper_ignored_blk got %h exp %h", BlockState, 4'h3);
    end
  endtask

  task automatic test_independent_ports();
    reg_addr = 10'b00010_00001;
    yBlockNum = 5'd31;
    xBlockNum = 5'd31;
    settle();
    checks++;
    if (data_out[3:0] !== 4'h9) begin
      errors++;
      $display("FAIL indep_dout got %h exp %h", data_out[3:0], 4'h9);
    end
    checks++;
    if (BlockState !== 4'h5) begin
      errors++;
      $display("FAIL indep_blk got %h exp %h", BlockState, 4'h5);
    end
  endtask

  task automatic test_reset_vs_store();
    rst = 1'b0;
    L_S = 1'b1;
    data_in = 32'h0000_0419;
    step();
    // Store on the first edge with reset released must land.
    rst = 1'b1;
    data_in = 32'h0000_3FF7;
    step();
    L_S = 1'b0;
    reg_addr = 10'b00010_00001;
    yBlockNum = 5'd31;
    xBlockNum = 5'd31;
    settle();
    checks++;
    if (data_out !== 32'h0000_0410) begin
      errors++;
      $display("FAIL reset_vs_store got %h exp %h", data_out, 32'h0000_0410);
    end
    checks++;
    if (BlockState !== 4'h7) begin
      errors++;
      $display("FAIL store_after_reset got %h exp %h", BlockState, 4'h7);
    end
  endtask

  task automatic test_read_during_write();
    reg_addr = 10'b00010_00001;
    L_S = 1'b1;
    data_in = 32'h0000_041A;
    #1;
    checks++;
    if (data_out !== 32'h0000_0410) begin
      errors++;
      $display("FAIL rdw_before_edge got %h exp %h", data_out, 32'h0000_0410);
    end
    step();
    L_S = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0000_041A) begin
      errors++;
      $display("FAIL rdw_after_edge got %h exp %h", data_out, 32'h0000_041A);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    L_S = 1'b0;
    reg_addr = '0;
    xBlockNum = '0;
    yBlockNum = '0;
    data_in = '0;
    step();
    test_reset();
    test_store_readback();
    test_addr_ignored();
    test_upper_ignored();
    test_independent_ports();
    test_reset_vs_store();
    test_read_during_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
